// File: rtl/ahb_rr_master_pkg.sv
// Shared types and helpers for the round-robin AHB-lite master.
`timescale 1ns/1ps
package ahb_rr_master_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  // Width of an encoded requester id; never narrower than one bit.
  function automatic int id_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/ahb_rr_master_rr_arbiter.sv
// Round-robin picker: first valid requester at or above the pointer, with wrap.
`timescale 1ns/1ps
module rr_arbiter
  import ahb_rr_master_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IdW = id_width(NUM_REQ)
) (
  input  logic               hclk,
  input  logic               hresetn,
  input  logic [NUM_REQ-1:0] valid,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [IdW-1:0]     grant_id
);

  logic [IdW-1:0] pointer_q;
  logic [IdW-1:0] pointer_d;
  logic           found;
  int             scan_idx;

  // The pointer only advances when a grant is actually consumed.
  always_comb begin
    grant     = '0;
    grant_id  = '0;
    found     = 1'b0;
    scan_idx  = 0;
    pointer_d = pointer_q;
    for (int off = 0; off < NUM_REQ; off++) begin
      scan_idx = (int'(pointer_q) + off) % NUM_REQ;
      if (!found && valid[scan_idx]) begin
        found    = 1'b1;
        grant_id = IdW'(scan_idx);
      end
    end
    if (enable && found) begin
      grant[grant_id] = 1'b1;
      pointer_d = (grant_id == IdW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    end
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      pointer_q <= '0;
    end else begin
      pointer_q <= pointer_d;
    end
  end

endmodule

// File: rtl/ahb_rr_master.sv
// AHB-lite master sharing one slave port between NUM_REQ requesters,
// with a pipelined address stage, data stage and response register.
`timescale 1ns/1ps
module ahb_rr_master
  import ahb_rr_master_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int addrWidth = 8,
  parameter int dataWidth = 32
) (
  input  logic                           hclk,
  input  logic                           hresetn,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_write,
  input  logic [NUM_REQ*addrWidth-1:0]   req_addr,
  input  logic [NUM_REQ*dataWidth-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [dataWidth-1:0]           rsp_rdata,
  output logic                           hselx,
  output logic [addrWidth-1:0]           haddr,
  output logic                           hwrite,
  output logic [1:0]                     htrans,
  output logic [dataWidth-1:0]           hwdata,
  input  logic                           hready,
  input  logic [dataWidth-1:0]           hrdata
);

  localparam int IdW = id_width(NUM_REQ);

  logic [NUM_REQ-1:0] grant;
  logic [IdW-1:0]     grant_id;
  logic               accept;
  logic               addr_valid;

  htrans_t              htrans_q, htrans_d;
  logic [addrWidth-1:0] haddr_q, haddr_d;
  logic                 hwrite_q, hwrite_d;
  logic [IdW-1:0]       addr_id_q, addr_id_d;
  logic [dataWidth-1:0] addr_wdata_q, addr_wdata_d;
  logic                 data_valid_q, data_valid_d;
  logic [IdW-1:0]       data_id_q, data_id_d;
  logic                 data_write_q, data_write_d;
  logic [dataWidth-1:0] hwdata_q, hwdata_d;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [dataWidth-1:0] rsp_rdata_q, rsp_rdata_d;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arbiter (
    .hclk     (hclk),
    .hresetn  (hresetn),
    .valid    (req_valid),
    .enable   (hresetn & hready),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign req_ready  = grant;
  assign accept     = |grant;
  assign addr_valid = (htrans_q == HTRANS_NONSEQ);

  // Everything advances together on hready; a low hready freezes the pipe.
  always_comb begin
    htrans_d     = htrans_q;
    haddr_d      = haddr_q;
    hwrite_d     = hwrite_q;
    addr_id_d    = addr_id_q;
    addr_wdata_d = addr_wdata_q;
    data_valid_d = data_valid_q;
    data_id_d    = data_id_q;
    data_write_d = data_write_q;
    hwdata_d     = hwdata_q;
    rsp_valid_d  = '0;
    rsp_rdata_d  = rsp_rdata_q;
    if (hready) begin
      if (accept) begin
        htrans_d     = HTRANS_NONSEQ;
        haddr_d      = req_addr[grant_id*addrWidth +: addrWidth];
        hwrite_d     = req_write[grant_id];
        addr_id_d    = grant_id;
        addr_wdata_d = req_wdata[grant_id*dataWidth +: dataWidth];
      end else begin
        htrans_d = HTRANS_IDLE;
      end
      data_valid_d = addr_valid;
      data_id_d    = addr_id_q;
      data_write_d = hwrite_q;
      if (addr_valid && hwrite_q) begin
        hwdata_d = addr_wdata_q;
      end
      if (data_valid_q) begin
        rsp_valid_d[data_id_q] = 1'b1;
        rsp_rdata_d = data_write_q ? '0 : hrdata;
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      htrans_q     <= HTRANS_IDLE;
      haddr_q      <= '0;
      hwrite_q     <= 1'b0;
      addr_id_q    <= '0;
      addr_wdata_q <= '0;
      data_valid_q <= 1'b0;
      data_id_q    <= '0;
      data_write_q <= 1'b0;
      hwdata_q     <= '0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
    end else begin
      htrans_q     <= htrans_d;
      haddr_q      <= haddr_d;
      hwrite_q     <= hwrite_d;
      addr_id_q    <= addr_id_d;
      addr_wdata_q <= addr_wdata_d;
      data_valid_q <= data_valid_d;
      data_id_q    <= data_id_d;
      data_write_q <= data_write_d;
      hwdata_q     <= hwdata_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
    end
  end

  assign htrans    = htrans_q;
  assign hselx     = addr_valid;
  assign haddr     = haddr_q;
  assign hwrite    = hwrite_q;
  assign hwdata    = hwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: doc/ahb_rr_master.md
Name: ahb_rr_master

Overview:
- Multi-requester AHB-lite master that shares one AHB slave port (the single-cycle memory slave) between NUM_REQ local requesters.
- Round-robin arbitration; issues single NONSEQ transfers, pipelined address/data phases, one transfer per cycle when hready is high.
- Returns read data or write acknowledgement to the originating requester.
- Sits between block-level clients and the AHB slave memory.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- addrWidth, 8, AHB address width (matches slave).
- dataWidth, 32, AHB data width (matches slave).

Ports:
- hclk  input  1  clock; all logic on rising edge.
- hresetn  input  1  synchronous active-low reset, sampled on rising hclk.
- req_valid  input  NUM_REQ  per-requester request pending.
- req_write  input  NUM_REQ  1=write, 0=read.
- req_addr  input  NUM_REQ*addrWidth  packed; slice i = requester i address.
- req_wdata  input  NUM_REQ*dataWidth  packed write data.
- req_ready  output  NUM_REQ  one-hot accept (combinational); request consumed at edge where valid&ready.
- rsp_valid  output  NUM_REQ  one-hot, one-cycle completion pulse.
- rsp_rdata  output  dataWidth  read data for rsp_valid requester (0 on writes).
- hselx  output  1  slave select; high exactly when htrans=NONSEQ.
- haddr  output  addrWidth  address-phase address.
- hwrite  output  1  address-phase direction.
- htrans  output  2  IDLE(00) or NONSEQ(10) only.
- hwdata  output  dataWidth  data-phase write data.
- hready  input  1  slave ready; low stalls both phases.
- hrdata  input  dataWidth  slave read data, valid in data phase.

Behaviour:
- Reset (hresetn low at edge): htrans=IDLE, hselx=0, haddr=0, hwrite=0, hwdata=0, rsp_valid=0, rsp_rdata=0, rr pointer=0, both phase pipeline stages invalid. req_ready=0 while hresetn low.
- Reset mid-operation: in-flight transfers discarded; no rsp_valid generated for them.
- Grant: req_ready[i]=1 iff hresetn & hready & req_valid[i] & i is first valid index scanning from pointer upward with wrap. At most one bit set.
- Pointer: on accepted grant to i, pointer <= (i+1) mod NUM_REQ; unchanged otherwise.
- Edge E0 (accept): address stage loads haddr=req_addr[i], hwrite=req_write[i], htrans=NONSEQ, hselx=1; stores id i and wdata.
- No accept at E0 with hready=1: htrans=IDLE, hselx=0; haddr/hwrite hold.
- E1 (next edge with hready=1): address stage moves to data stage; hwdata driven from stored wdata (writes), held otherwise.
- E2 (next edge with hready=1): data phase ends; rsp_valid[id]=1 for the cycle after E2; rsp_rdata=hrdata sampled at E2 for reads, 0 for writes.
- Latency: accept edge to rsp_valid = 3 edges. Throughput: 1 transfer/cycle back-to-back.
- hready low at an edge: all AHB outputs, pipeline stages and pointer hold; no grant; rsp_valid=0 next cycle.
- Write followed immediately by read to same address: read returns old data (slave commits write at end of data phase, read sampled at end of address phase). Requesters needing read-after-write must wait for write rsp_valid.
- All requesters idle: continuous IDLE; pointer unchanged.

Decomposition:
- ahb_pkg: htrans_t enum (IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11); requester-id width constant via $clog2.
- Sub-module rr_arbiter: NUM_REQ-wide round-robin picker with pointer register, inputs valid + advance enable, output one-hot grant and encoded id.
- Top holds address/data pipeline stages and response register.

Test Plan:
- Reset then single write: req0 write addr 0x10 data 0xDEADBEEF -> htrans=NONSEQ/haddr=0x10 cycle after accept, hwdata=0xDEADBEEF next cycle, rsp_valid[0] 3 edges after accept, rsp_rdata=0.
- Read back: req2 read 0x10 after the write completes -> rsp_valid[2] at +3 edges, rsp_rdata=0xDEADBEEF.
- Fairness: all 4 requesters valid continuously, writes to 0x00..0x03 -> grants 0,1,2,3,0,1 on consecutive cycles, htrans NONSEQ every cycle, rsp_valid one-hot in same order.
- Pointer wrap: only req3 and req1 valid, pointer=2 -> grant 3 then 1, then pointer=2.
- hready startup: release reset with req0 valid -> no req_ready until hready high (slave drives hready=0 first cycle after reset), then normal accept.
- Reset mid-flight: assert hresetn=0 one cycle after accepting req1 read -> htrans=IDLE, no rsp_valid[1] after reset release, pointer=0.
